// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   DEFAULT_RESET_PC  - PC the fetch stage starts from after reset
//   DEFAULT_NOP_INSTR - bubble instruction (addi x0,x0,0) shown when idle
//   fetch_entry_t     - one returned instruction word paired with its PC
//   alignWord()       - clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO with synchronous clear and occupancy count.
//   clk, rst     - clock, asynchronous active-high reset
//   clr_i        - empties the FIFO at the next edge (wins over push/pop)
//   push_i       - write push_data_i (ignored when full and not popping)
//   pop_i        - drop the head entry (ignored when empty)
//   head_o       - current head entry (don't-care when empty)
//   count_o      - number of stored entries, 0..DEPTH
//   empty_o      - no entries stored
// DEPTH must be a power of two so the pointers wrap on their own.
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Fetch stage feeding the IF/ID buffer. Owns the PC, issues pipelined
// instruction-memory reads and queues the returned words.
//   clk, rst        - clock, asynchronous active-high reset
//   stall           - IF/ID buffer holds; the head instruction is not consumed
//   flush           - redirect from EX; discards all wrong-path work
//   redirect_pc     - redirect target (byte offset ignored)
//   imem_req/addr   - fetch request and word address
//   imem_gnt        - request accepted this cycle
//   imem_rvalid/rdata - in-order read return
//   instruction_IF, pc_IF, valid_IF - instruction presented to IF/ID
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] NOP_INSTR       = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_IF,
    output logic [31:0] pc_IF,
    output logic        valid_IF
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;

    logic [31:0]      pend_head;
    logic [CNT_W-1:0] pend_count;
    logic             pend_empty;
    fetch_entry_t     out_head;
    fetch_entry_t     out_push_data;
    logic [CNT_W-1:0] out_count;
    logic             out_empty;

    logic [CNT_W:0]   credits_used;
    logic             grant;
    logic             rsp_valid;
    logic             out_push;
    logic             out_pop;

    // Every word in flight or waiting in the out queue holds a credit, so the
    // out queue can always absorb whatever memory returns.
    assign credits_used = {1'b0, pend_count} + {1'b0, out_count};
    assign imem_req     = !rst && !flush && (credits_used < (CNT_W + 1)'(MAX_OUTSTANDING));
    assign imem_addr    = fetch_pc_q;
    assign grant        = imem_req && imem_gnt;

    // A return with nothing pending cannot be matched to a PC and is ignored.
    assign rsp_valid     = imem_rvalid && !pend_empty;
    assign out_push      = rsp_valid && !flush && (stale_cnt_q == '0);
    assign out_pop       = !stall && !flush && !out_empty;
    assign out_push_data = '{instr: imem_rdata, pc: pend_head};

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pending (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (1'b0),
        .push_i      (grant),
        .push_data_i (fetch_pc_q),
        .pop_i       (rsp_valid),
        .head_o      (pend_head),
        .count_o     (pend_count),
        .empty_o     (pend_empty)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_out_queue (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (flush),
        .push_i      (out_push),
        .push_data_i (out_push_data),
        .pop_i       (out_pop),
        .head_o      (out_head),
        .count_o     (out_count),
        .empty_o     (out_empty)
    );

    // On a redirect every word still in flight is wrong-path; the pending FIFO
    // keeps those PCs so their returns can be counted off and dropped. A word
    // returning in the flush cycle itself is already gone from that count.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        stale_cnt_d = stale_cnt_q;
        if (flush) begin
            fetch_pc_d  = alignWord(redirect_pc);
            stale_cnt_d = pend_count - (rsp_valid ? CNT_W'(1) : CNT_W'(0));
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_valid && (stale_cnt_q != '0)) begin
                stale_cnt_d = stale_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            stale_cnt_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign valid_IF       = !out_empty;
    assign instruction_IF = out_empty ? NOP_INSTR : out_head.instr;
    assign pc_IF          = out_empty ? fetch_pc_q : out_head.pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage: the producer that feeds the IF/ID pipeline buffer.
- Owns the program counter, issues pipelined instruction-memory requests over a req/gnt + rvalid interface, and queues the returned words.
- Presents one instruction and its PC per cycle to the IF/ID buffer, honouring the same `stall` that freezes that buffer.
- Handles branch/jump redirects from the execute stage by discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MAX_OUTSTANDING, 4, maximum words in flight plus words queued (credit limit); power of two, ≥2.
- NOP_INSTR, 32'h0000_0013, instruction driven when no valid word is present (addi x0,x0,0).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- stall  in  1  hazard-unit stall; IF/ID buffer holds this cycle
- flush  in  1  redirect request from EX
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (word aligned)
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  read data valid; in-order, ≥1 cycle after grant
- imem_rdata  in  32  read data
- instruction_IF  out  32  instruction to IF/ID buffer
- pc_IF  out  32  PC of instruction_IF
- valid_IF  out  1  instruction_IF/pc_IF are a real fetch

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- State:
  - fetch_pc.
  - pending FIFO of issued PCs, depth MAX_OUTSTANDING.
  - out queue of {instr, pc}, depth MAX_OUTSTANDING.
  - stale_cnt, width clog2(MAX_OUTSTANDING)+1.
- Reset (async, immediate):
  - fetch_pc=RESET_PC; both FIFOs empty; stale_cnt=0.
  - imem_req=0, valid_IF=0, instruction_IF=NOP_INSTR, pc_IF=RESET_PC.
- Issue:
  - imem_req = !flush && (pending_count + out_count) < MAX_OUTSTANDING.
  - imem_addr = fetch_pc.
  - On req&&gnt: push fetch_pc to pending, then fetch_pc += 4. Arithmetic is modulo 2^32, so 0xFFFF_FFFC wraps to 0.
  - While gnt=0, imem_req and imem_addr are held stable.
- Response on imem_rvalid: pop the pending head.
  - stale_cnt>0 → decrement it and drop the word.
  - Else → push {imem_rdata, popped pc} into the out queue.
  - rvalid with pending empty is ignored; bench asserts it never happens.
- Output (combinational from out queue head):
  - Non-empty → valid_IF=1, instruction_IF/pc_IF = head.
  - Empty → valid_IF=0, instruction_IF=NOP_INSTR, pc_IF=fetch_pc.
- Consume: head popped at the clock edge when !stall && !flush && out queue non-empty.
- Latency:
  - Word with rvalid in cycle N is on instruction_IF in cycle N+1.
  - Earliest first valid_IF is cycle 2 after reset release, with 1-cycle memory.
- Credit: the queue can never overflow, because every outstanding word already holds a slot.
- Flush (priority over stall and responses):
  - fetch_pc <= redirect_pc.
  - Out queue cleared.
  - stale_cnt <= pending_count − (imem_rvalid ? 1 : 0).
  - Any response in the flush cycle is dropped.
  - imem_req=0 in the flush cycle.
  - First redirected request is issued the next cycle.
- Back-to-back flushes: the later target wins; stale_cnt is recomputed each time, so every earlier in-flight word is dropped.
- Stall: outputs hold; fetching continues until credits are exhausted.
- Reset asserted mid-operation discards all state. The memory side is reset by the same rst.

Decomposition:
- fetch_pkg:
  - NOP_INSTR, RESET_PC defaults.
  - typedef fetch_entry_t {logic [31:0] instr; logic [31:0] pc;}.
- One sub-module, fetch_fifo: parameterized width/depth sync FIFO with clear, count, async active-high reset. It is instantiated twice: pending (32-bit) and out queue (fetch_entry_t).

Test Plan:
- Reset release, gnt=1, rvalid one cycle after grant with rdata=addr|0xA000_0000 → imem_addr 0x0,0x4,0x8…; valid_IF from cycle 2 with pc_IF 0x0,0x4,0x8 and matching data, no gaps.
- stall=1 for 6 cycles mid-stream at pc_IF=0x8 → outputs hold 0x8; imem_req drops once 4 credits are used; after release the PCs continue 0xC,0x10… with no loss or duplication.
- flush with redirect_pc=0x100 while 3 words are in flight → those 3 responses are dropped; the next valid_IF has pc_IF=0x100, then 0x104.
- flush 0x100 then flush 0x200 on consecutive cycles, memory latency 3 → no 0x100-path or old-path word appears; the first valid pc_IF is 0x200.
- imem_gnt=0 for 5 cycles → imem_addr stable at 0x10; queue drains; valid_IF=0 with instruction_IF=0x0000_0013.
- rst pulsed asynchronously between edges mid-stream → outputs take reset values immediately; fetch restarts at RESET_PC after release.
